prbs_gen_meter: RTL

- Parametrised successor to the 8-bit PRBS generator: a WIDTH-bit Fibonacci LFSR with a runtime feedback mask.
- Adds clock enable, synchronous seed load and all-zero lock-up recovery.
- Has a built-in period meter that counts advances until the state sequence repeats, so repetition-length checks move from the bench into hardware.
- Sits as a stimulus/noise source feeding lab datapaths, and as a self-checking mask explorer.

---
 rtl/prbs_pkg.sv | 29 ++
 rtl/prbs_period_meter.sv | 92 +++++++++
 rtl/prbs_gen_meter.sv | 106 ++++++++++
 3 files changed

// File: rtl/prbs_pkg.sv
// prbs_pkg: shared constants and the LFSR step function for prbs_gen_meter.
//   DEF_MASK8 / MAX_MASK8 : 8-bit feedback masks known to give period 255.
//   lfsr_next()           : one Fibonacci step without all-zero recovery, so
//                           it also serves as a plain reference model.
package prbs_pkg;

  // Widest state the step function supports; callers zero-extend.
  localparam int MAX_W = 64;

  localparam logic [7:0] DEF_MASK8 = 8'he1;
  localparam logic [7:0] MAX_MASK8 = 8'hB8;

  // One LFSR advance: fb = ^(cur & taps), shift left, insert fb at bit 0.
  // Only the low 'width' bits of the result are meaningful; the rest are 0.
  function automatic logic [MAX_W-1:0] lfsr_next(input logic [MAX_W-1:0] cur,
                                                 input logic [MAX_W-1:0] taps,
                                                 input int width);
    logic [MAX_W-1:0] keep;
    logic             fb;
    if (width >= MAX_W) begin
      keep = {MAX_W{1'b1}};
    end else begin
      keep = (64'd1 << width) - 64'd1;
    end
    fb = ^(cur & taps & keep);
    return ((cur << 1) | {{(MAX_W-1){1'b0}}, fb}) & keep;
  endfunction

endpackage

// File: rtl/prbs_period_meter.sv
// prbs_period_meter: counts LFSR advances until the state returns to a
// reference value captured at restart.
//   clk, reset      : clock and asynchronous active-high reset
//   restart         : reload ref with restart_value and clear all results
//   adv             : LFSR advances this cycle to nxt_state
//   nxt_state       : state the LFSR takes on this edge
//   restart_value   : new reference value (already zero-recovered)
//   period          : last measured period (advances between repeats)
//   period_valid    : sticky, a repeat was seen since reset/restart
//   period_ovf      : sticky, the counter saturated without a repeat
module prbs_period_meter #(
  parameter int              WIDTH     = 8,
  parameter int              CNT_W     = WIDTH + 2,
  parameter logic [WIDTH-1:0] RESET_REF = {WIDTH{1'b1}}
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             restart,
  input  logic             adv,
  input  logic [WIDTH-1:0] nxt_state,
  input  logic [WIDTH-1:0] restart_value,
  output logic [CNT_W-1:0] period,
  output logic             period_valid,
  output logic             period_ovf
);

  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_PRE  = {{(CNT_W-1){1'b1}}, 1'b0};

  logic [WIDTH-1:0] ref_q,    ref_d;
  logic [CNT_W-1:0] cnt_q,    cnt_d;
  logic [CNT_W-1:0] period_q, period_d;
  logic             valid_q,  valid_d;
  logic             ovf_q,    ovf_d;

  // Next-value logic for the reference, counter and result registers.
  always_comb begin
    ref_d    = ref_q;
    cnt_d    = cnt_q;
    period_d = period_q;
    valid_d  = valid_q;
    ovf_d    = ovf_q;
    if (restart) begin
      ref_d    = restart_value;
      cnt_d    = CNT_ZERO;
      period_d = CNT_ZERO;
      valid_d  = 1'b0;
      ovf_d    = 1'b0;
    end else if (adv) begin
      if (nxt_state == ref_q) begin
        // Repeat found: publish and rearm against the same reference.
        // A saturated count wraps here; ovf stays set to flag it.
        period_d = cnt_q + CNT_ONE;
        valid_d  = 1'b1;
        cnt_d    = CNT_ZERO;
      end else if (cnt_q == CNT_PRE) begin
        cnt_d = CNT_MAX;
        ovf_d = 1'b1;
      end else if (cnt_q == CNT_MAX) begin
        cnt_d = CNT_MAX;
      end else begin
        cnt_d = cnt_q + CNT_ONE;
      end
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Meter registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ref_q    <= RESET_REF;
      cnt_q    <= CNT_ZERO;
      period_q <= CNT_ZERO;
      valid_q  <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      ref_q    <= ref_d;
      cnt_q    <= cnt_d;
      period_q <= period_d;
      valid_q  <= valid_d;
      ovf_q    <= ovf_d;
    end
  end

  assign period       = period_q;
  assign period_valid = valid_q;
  assign period_ovf   = ovf_q;

endmodule

// File: rtl/prbs_gen_meter.sv
// prbs_gen_meter: WIDTH-bit Fibonacci LFSR with runtime feedback mask,
// clock enable, seed load, all-zero lock-up recovery and a period meter.
//   clk, reset   : clock and asynchronous active-high reset
//   en           : advance one step (ignored when load is high)
//   load         : load seed (0 becomes 1) and restart the meter
//   seed, mask   : load value and feedback taps
//   rand1        : serial output, state[WIDTH-1]
//   state        : current LFSR state
//   period, period_valid, period_ovf : meter results
//   zero_recov   : sticky, an all-zero state was replaced by 1
module prbs_gen_meter
  import prbs_pkg::*;
#(
  parameter int               WIDTH      = 8,
  parameter int               CNT_W      = WIDTH + 2,
  parameter logic [WIDTH-1:0] RESET_SEED = {WIDTH{1'b1}}
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] seed,
  input  logic [WIDTH-1:0] mask,
  output logic             rand1,
  output logic [WIDTH-1:0] state,
  output logic [CNT_W-1:0] period,
  output logic             period_valid,
  output logic             period_ovf,
  output logic             zero_recov
);

  localparam logic [WIDTH-1:0] ST_ZERO = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] ST_ONE  = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0] state_q, state_d;
  logic             zero_recov_q, zero_recov_d;
  logic [WIDTH-1:0] nxt_s;
  logic             state_zero_s;
  logic [WIDTH-1:0] seed_fix_s;
  logic             seed_zero_s;
  logic             adv_s;

  // Step function with lock-up recovery, and zero-safe load value.
  always_comb begin
    state_zero_s = (state_q == ST_ZERO);
    seed_zero_s  = (seed == ST_ZERO);
    if (state_zero_s) begin
      nxt_s = ST_ONE;
    end else begin
      nxt_s = WIDTH'(lfsr_next(MAX_W'(state_q), MAX_W'(mask), WIDTH));
    end
    if (seed_zero_s) begin
      seed_fix_s = ST_ONE;
    end else begin
      seed_fix_s = seed;
    end
    adv_s = en & ~load;
  end

  // Next state and sticky recovery flag; load has priority over en.
  always_comb begin
    state_d      = state_q;
    zero_recov_d = zero_recov_q;
    if (load) begin
      state_d      = seed_fix_s;
      zero_recov_d = seed_zero_s;
    end else if (en) begin
      state_d      = nxt_s;
      zero_recov_d = zero_recov_q | state_zero_s;
    end else begin
      state_d = state_q;
    end
  end

  // LFSR state and recovery flag registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= RESET_SEED;
      zero_recov_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      zero_recov_q <= zero_recov_d;
    end
  end

  prbs_period_meter #(
    .WIDTH     (WIDTH),
    .CNT_W     (CNT_W),
    .RESET_REF (RESET_SEED)
  ) u_meter (
    .clk           (clk),
    .reset         (reset),
    .restart       (load),
    .adv           (adv_s),
    .nxt_state     (nxt_s),
    .restart_value (seed_fix_s),
    .period        (period),
    .period_valid  (period_valid),
    .period_ovf    (period_ovf)
  );

  assign rand1      = state_q[WIDTH-1];
  assign state      = state_q;
  assign zero_recov = zero_recov_q;

endmodule
